pipe_adder: RTL

- Parametrised, pipelined add/subtract unit; successor to the team's fixed 4-bit combinational ripple adder.
- The WIDTH-bit operation is split into STAGES equal chunks. Each chunk is added in its own pipeline stage, and the carry is registered between stages.
- Accepts one operation per clock when not stalled.
- Used in datapaths where a wide add cannot close timing in one cycle.

---
 rtl/pipe_adder_pkg.sv | 14 +
 rtl/adder_chunk.sv | 22 ++
 rtl/pipe_adder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
package pipe_adder_pkg;

  // Encoding of the sub input.
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Bits handled by each pipeline stage.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit adder slice with carry in/out; one per pipeline stage.
module adder_chunk
  import pipe_adder_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] A,
  input  logic [CW-1:0] B,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          co
);

  logic [CW:0] total;

  // CW+1-bit add; the top bit is the chunk carry.
  always_comb begin
    total     = {1'b0, A} + {1'b0, B} + {{CW{1'b0}}, cin};
    {co, sum} = total;
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one CW-bit chunk per stage, carry registered
// between stages, operands skewed forward and partial sums de-skewed so
// every chunk of an operation leaves the pipe on the same cycle.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             stall,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovfl,
  output logic             out_vld
);

  localparam int unsigned CW = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH (%0d) must be a multiple of STAGES (%0d), 1 <= STAGES <= WIDTH",
           WIDTH, STAGES);
  end

  logic [WIDTH-1:0] beff;
  logic             c0;

  // Subtract is A + ~B + 1; carry-in only matters when adding.
  always_comb begin
    beff = (sub == ADD) ? B : ~B;
    c0   = (sub == SUB) ? 1'b1 : cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_d, b_d, s_d;
    logic             c_d, v_d;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_q, v_q;
    logic [WIDTH-1:0] s_next;
    logic [CW-1:0]    part;
    logic             carry;

    if (k == 0) begin : g_head
      // First stage works straight from the ports.
      always_comb begin
        a_d = A;
        b_d = beff;
        s_d = '0;
        c_d = c0;
        v_d = in_vld;
      end
    end else begin : g_body
      // Later stages take the previous level's skewed operands and carry.
      always_comb begin
        a_d = g_stage[k-1].a_q;
        b_d = g_stage[k-1].b_q;
        s_d = g_stage[k-1].s_q;
        c_d = g_stage[k-1].c_q;
        v_d = g_stage[k-1].v_q;
      end
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .A   (a_d[k*CW +: CW]),
      .B   (b_d[k*CW +: CW]),
      .cin (c_d),
      .sum (part),
      .co  (carry)
    );

    // Drop this stage's chunk into the travelling partial sum.
    always_comb begin
      s_next               = s_d;
      s_next[k*CW +: CW]   = part;
    end

    // Stage register: operands, partial sum, carry and valid move together.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (!stall) begin
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_next;
        c_q <= carry;
        v_q <= v_d;
      end
    end
  end

  logic [WIDTH-1:0] a_last, b_last;

  // Outputs come from the last register level; ovfl uses the delayed MSBs.
  always_comb begin
    a_last  = g_stage[STAGES-1].a_q;
    b_last  = g_stage[STAGES-1].b_q;
    sum     = g_stage[STAGES-1].s_q;
    co      = g_stage[STAGES-1].c_q;
    out_vld = g_stage[STAGES-1].v_q;
    ovfl    = (a_last[WIDTH-1] == b_last[WIDTH-1]) &&
              (sum[WIDTH-1] != a_last[WIDTH-1]);
  end

  // Only the operand MSBs are needed past the last chunk adder.
  if (WIDTH > 1) begin : g_low_sink
    logic unused_skew_low;
    assign unused_skew_low = ^{a_last[WIDTH-2:0], b_last[WIDTH-2:0]};
  end

endmodule
